// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the load/store stage and the data memory controller.
// The master drives requests. The slave (the memory) returns ready and the response.
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Little-endian, word-organised data memory with byte/half/word access and load extension.
// A misaligned access is split into two word beats. An illegal or out-of-range access faults.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_WORDS    = 64,
  parameter bit          MISALIGN_SPLIT = 1'b1,
  parameter bit          INIT_PATTERN   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_ctrl_if.slave  bus
);
  localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] NBYTES = 33'(4 * DEPTH_WORDS);

  typedef logic [3:0][7:0] word_t;
  typedef word_t mem_t [DEPTH_WORDS];
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BEAT2 = 1'b1} state_t;

  function automatic mem_t f_init_mem();
    mem_t m;
    for (int w = 0; w < int'(DEPTH_WORDS); w++) begin
      for (int l = 0; l < 4; l++) begin
        m[w][l] = INIT_PATTERN ? 8'(4 * w + l) : 8'h00;
      end
    end
    return m;
  endfunction

  function automatic logic [2:0] f_bytes(input logic [1:0] size);
    case (size)
      2'b00:   f_bytes = 3'd1;
      2'b01:   f_bytes = 3'd2;
      2'b10:   f_bytes = 3'd4;
      default: f_bytes = 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] f_extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sgn);
    case (size)
      2'b00:   f_extend = {{24{sgn & raw[7]}}, raw[7:0]};
      2'b01:   f_extend = {{16{sgn & raw[15]}}, raw[15:0]};
      default: f_extend = raw;
    endcase
  endfunction

  // Contents are preloaded at power-up and are never cleared by reset.
  mem_t r_mem = f_init_mem();

  state_t      r_state, w_next_state;
  logic        r_write, r_signed;
  logic [1:0]  r_size, r_lo;
  logic [AW-1:0] r_word;
  logic [31:0] r_wdata, r_raw;
  logic        r_rsp_valid, r_rsp_fault;
  logic [31:0] r_rsp_rdata;

  logic        w_in_beat2, w_accept, w_misaligned, w_fault, w_split, w_mem_go;
  logic        w_write, w_signed, w_capture;
  logic [1:0]  w_size, w_lo;
  logic [2:0]  w_bytes;
  logic [32:0] w_last_addr;
  logic [AW-1:0] w_word;
  logic [31:0] w_wdata, w_raw_beat, w_raw_full;
  word_t       w_rd_word, w_lane_wdata;
  logic [3:0][3:0] w_k;
  logic [3:0]  w_lane_act, w_lane_wr;
  logic        w_rsp_valid_nxt, w_rsp_fault_nxt;
  logic [31:0] w_rsp_rdata_nxt;

  assign w_in_beat2 = (r_state == S_BEAT2);
  assign w_accept   = bus.req_valid && (r_state == S_IDLE) && !reset;
  assign w_write    = w_in_beat2 ? r_write  : bus.req_write;
  assign w_signed   = w_in_beat2 ? r_signed : bus.req_signed;
  assign w_size     = w_in_beat2 ? r_size   : bus.req_size;
  assign w_lo       = w_in_beat2 ? r_lo     : bus.req_addr[1:0];
  assign w_word     = w_in_beat2 ? r_word   : bus.req_addr[AW+1:2];
  assign w_wdata    = w_in_beat2 ? r_wdata  : bus.req_wdata;
  assign w_bytes    = f_bytes(w_size);
  assign w_rd_word  = r_mem[w_word];
  assign w_raw_full = w_in_beat2 ? (r_raw | w_raw_beat) : w_raw_beat;

  // Classify the incoming request (meaningful only in IDLE).
  always_comb begin
    w_misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    w_last_addr  = {1'b0, bus.req_addr} + 33'(w_bytes) - 33'd1;
    w_fault      = (bus.req_size == 2'b11) || (w_last_addr >= NBYTES) ||
                   (w_misaligned && !MISALIGN_SPLIT);
    w_split      = w_misaligned && !w_fault;
    w_mem_go     = (w_accept && !w_fault) || (w_in_beat2 && !reset);
  end

  // Map each lane of the addressed word to its byte offset k within the access.
  // k wraps high for lanes below the start lane in beat 1, which deselects them.
  always_comb begin
    w_raw_beat = 32'h0;
    for (int l = 0; l < 4; l++) begin
      w_k[l]          = 4'(l) - {2'b00, w_lo} + (w_in_beat2 ? 4'd4 : 4'd0);
      w_lane_act[l]   = (w_k[l] < {1'b0, w_bytes});
      w_lane_wr[l]    = w_lane_act[l] && w_write && w_mem_go;
      w_lane_wdata[l] = w_wdata[{w_k[l][1:0], 3'b000} +: 8];
      w_raw_beat      = w_raw_beat |
                        ({24'h0, (w_lane_act[l] ? w_rd_word[l] : 8'h00)} << {w_k[l][1:0], 3'b000});
    end
  end

  // Next-state and next-response logic.
  always_comb begin
    w_next_state    = r_state;
    w_capture       = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_fault_nxt = r_rsp_fault;
    w_rsp_rdata_nxt = r_rsp_rdata;
    case (r_state)
      S_IDLE: begin
        if (!w_accept) begin
          w_next_state = S_IDLE;
        end else if (w_fault) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_fault_nxt = 1'b1;
          w_rsp_rdata_nxt = 32'h0;
        end else if (w_split) begin
          w_next_state = S_BEAT2;
          w_capture    = 1'b1;
        end else begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_fault_nxt = 1'b0;
          w_rsp_rdata_nxt = w_write ? 32'h0 : f_extend(w_raw_full, w_size, w_signed);
        end
      end
      S_BEAT2: begin
        w_next_state    = S_IDLE;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_fault_nxt = 1'b0;
        w_rsp_rdata_nxt = w_write ? 32'h0 : f_extend(w_raw_full, w_size, w_signed);
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_state     <= w_next_state;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_fault <= w_rsp_fault_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  // Hold the request context and beat-1 load bytes across the second beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'b00;
      r_lo     <= 2'b00;
      r_word   <= '0;
      r_wdata  <= 32'h0;
      r_raw    <= 32'h0;
    end else if (w_capture) begin
      r_write  <= bus.req_write;
      r_signed <= bus.req_signed;
      r_size   <= bus.req_size;
      r_lo     <= bus.req_addr[1:0];
      r_word   <= bus.req_addr[AW+1:2] + AW'(1);
      r_wdata  <= bus.req_wdata;
      r_raw    <= w_raw_beat;
    end
  end

  // Byte-lane writes into the addressed word.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (w_lane_wr[l]) begin
        r_mem[w_word][l] <= w_lane_wdata[l];
      end
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_fault = r_rsp_fault;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed table-driven bench for data_memory_ctrl: one split-capable instance and one that
// faults on misalignment, plus hand sequences for the reset state, response hold and reset during BEAT2.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_memory_ctrl_if bus1 ();
  data_memory_ctrl_if bus0 ();

  logic        tb_valid, tb_sel0, tb_write, tb_sgn;
  logic [1:0]  tb_size;
  logic [31:0] tb_addr, tb_wdata;

  assign bus1.req_valid  = tb_valid & ~tb_sel0;
  assign bus1.req_write  = tb_write;
  assign bus1.req_size   = tb_size;
  assign bus1.req_signed = tb_sgn;
  assign bus1.req_addr   = tb_addr;
  assign bus1.req_wdata  = tb_wdata;
  assign bus0.req_valid  = tb_valid & tb_sel0;
  assign bus0.req_write  = tb_write;
  assign bus0.req_size   = tb_size;
  assign bus0.req_signed = tb_sgn;
  assign bus0.req_addr   = tb_addr;
  assign bus0.req_wdata  = tb_wdata;

  logic        obs_ready, obs_valid, obs_fault;
  logic [31:0] obs_rdata;
  assign obs_ready = tb_sel0 ? bus0.req_ready : bus1.req_ready;
  assign obs_valid = tb_sel0 ? bus0.rsp_valid : bus1.rsp_valid;
  assign obs_fault = tb_sel0 ? bus0.rsp_fault : bus1.rsp_fault;
  assign obs_rdata = tb_sel0 ? bus0.rsp_rdata : bus1.rsp_rdata;

  data_memory_ctrl #(.DEPTH_WORDS(64), .MISALIGN_SPLIT(1'b1), .INIT_PATTERN(1'b1)) u_dut_split (
    .clk(clk), .reset(reset), .bus(bus1));
  data_memory_ctrl #(.DEPTH_WORDS(64), .MISALIGN_SPLIT(1'b0), .INIT_PATTERN(1'b1)) u_dut_nosplit (
    .clk(clk), .reset(reset), .bus(bus0));

  typedef struct {
    logic        sel0;
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];
  int n_total = 0;
  int n_bad   = 0;

  function automatic vec_t mk(input logic sel0, input logic write, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_fault, input int exp_lat);
    vec_t v;
    v.sel0 = sel0; v.write = write; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a sample point (#1 after a rising edge); returns at the response sample point.
  task automatic run_req(input vec_t v, input string tag);
    int lat;
    tb_sel0 = v.sel0;
    #0;
    chk({tag, "_ready_pre"}, {31'h0, obs_ready}, 32'h1);
    tb_write = v.write; tb_size = v.size; tb_sgn = v.sgn;
    tb_addr = v.addr; tb_wdata = v.wdata; tb_valid = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    tb_addr  = 32'hFFFF_FFFF;
    tb_wdata = 32'h0BAD_0BAD;
    lat = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (c == 1 && v.exp_lat == 2) chk({tag, "_ready_beat2"}, {31'h0, obs_ready}, 32'h0);
      if (obs_valid) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_rdata"}, obs_rdata, v.exp_rdata);
    chk({tag, "_fault"}, {31'h0, obs_fault}, {31'h0, v.exp_fault});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; tb_valid = 1'b0; tb_sel0 = 1'b0; tb_write = 1'b0; tb_sgn = 1'b0;
    tb_size = 2'b00; tb_addr = 32'h0; tb_wdata = 32'h0;

    vecs[0]  = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        32'h07060504, 1'b0, 1);
    vecs[1]  = mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 32'h00000000, 1'b0, 1);
    vecs[2]  = mk(1'b0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'hFFFFFFAB, 1'b0, 1);
    vecs[3]  = mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'h000000AB, 1'b0, 1);
    vecs[4]  = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1312AB10, 1'b0, 1);
    vecs[5]  = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hDEADBEEF, 32'h00000000, 1'b0, 2);
    vecs[6]  = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'hBEEF2120, 1'b0, 1);
    vecs[7]  = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0,        32'h2726DEAD, 1'b0, 1);
    vecs[8]  = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'hFE, 32'h0,        32'h00000000, 1'b1, 1);
    vecs[9]  = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'hFF, 32'h00005A5A, 32'h00000000, 1'b1, 1);
    vecs[10] = mk(1'b0, 1'b0, 2'b00, 1'b0, 32'hFF, 32'h0,        32'h000000FF, 1'b0, 1);
    vecs[11] = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b1, 1);
    vecs[12] = mk(1'b0, 1'b0, 2'b01, 1'b1, 32'h80, 32'h0,        32'hFFFF8180, 1'b0, 1);
    vecs[13] = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h80, 32'h0,        32'h00008180, 1'b0, 1);
    vecs[14] = mk(1'b0, 1'b0, 2'b01, 1'b1, 32'h23, 32'h0,        32'hFFFFADBE, 1'b0, 2);
    vecs[15] = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h41, 32'h0,        32'h00004241, 1'b0, 2);
    vecs[16] = mk(1'b0, 1'b0, 2'b10, 1'b1, 32'hFC, 32'h0,        32'hFFFEFDFC, 1'b0, 1);
    vecs[17] = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h7E, 32'hFFFF1234, 32'h00000000, 1'b0, 1);
    vecs[18] = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0,        32'h12347D7C, 1'b0, 1);
    vecs[19] = mk(1'b0, 1'b0, 2'b00, 1'b1, 32'h80, 32'h0,        32'hFFFFFF80, 1'b0, 1);
    vecs[20] = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h01, 32'h0,        32'h00000000, 1'b1, 1);
    vecs[21] = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h02, 32'h0,        32'h00000302, 1'b0, 1);
    vecs[22] = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h03, 32'hCAFEF00D, 32'h00000000, 1'b1, 1);
    vecs[23] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        32'h03020100, 1'b0, 1);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready",   {31'h0, bus1.req_ready}, 32'h1);
    chk("rst_valid",   {31'h0, bus1.rsp_valid}, 32'h0);
    chk("rst_rdata",   bus1.rsp_rdata,          32'h0);
    chk("rst_fault",   {31'h0, bus1.rsp_fault}, 32'h0);
    chk("rst_ready_b", {31'h0, bus0.req_ready}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Pulse is one cycle wide and the data holds.
    @(posedge clk); #1;
    chk("hold_valid", {31'h0, obs_valid}, 32'h0);
    chk("hold_rdata", obs_rdata, 32'h03020100);

    // Split store abandoned by reset during BEAT2.
    tb_sel0 = 1'b0;
    #0;
    chk("rb_ready_pre", {31'h0, obs_ready}, 32'h1);
    tb_write = 1'b1; tb_size = 2'b10; tb_sgn = 1'b0;
    tb_addr = 32'h31; tb_wdata = 32'h11223344; tb_valid = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    chk("rb_ready_beat2", {31'h0, obs_ready}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rb_valid_in_rst", {31'h0, obs_valid}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rb_ready_after", {31'h0, obs_ready}, 32'h1);
    chk("rb_valid_after", {31'h0, obs_valid}, 32'h0);
    chk("rb_rdata_after", obs_rdata, 32'h0);
    run_req(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h22334430, 1'b0, 1), "rb_word30");
    run_req(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h34, 32'h0, 32'h00000034, 1'b0, 1), "rb_byte34");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
